// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - shared definitions for the j1 IO-bus UART peripheral
package j1_io_pkg;

    // Register offsets, selected by io_addr[2:1]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    // STATUS bit positions
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_IDLE   = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_RX_FRAME  = 4;
    localparam int ST_TX_OVF    = 5;

    // Baud divisor after reset: 100 MHz / 115200
    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd868;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Divisors below 2 would make the half-bit RX sample point degenerate
    function automatic logic [15:0] div_clamp(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/j1_io_fifo.sv
// rtl/j1_io_fifo.sv - 8-bit synchronous TX FIFO with push-when-full-and-popping acceptance
//  clk, rst_n        : clock, asynchronous active-low reset
//  push, push_data   : write request and byte
//  pop, pop_data     : read request; pop_data shows the head (valid when !empty)
//  full, empty       : occupancy flags
//  drop              : pulses when a push is refused (full and no simultaneous pop)
module j1_io_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    logic [7:0]  mem [2**AW];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/j1_io_uart.sv
// rtl/j1_io_uart.sv - memory-mapped UART responder on the j1 CPU IO bus
//  sys_clk_i, sys_rst_i : clock, asynchronous active-low reset
//  io_rd, io_wr         : single-cycle CPU strobes
//  io_addr, io_dout     : CPU byte address and write data
//  io_din               : read data, zero when this block is not addressed (OR-combinable)
//  uart_rx_i, uart_tx_o : serial line in (asynchronous) and out (idle high)
module j1_io_uart
    import j1_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);

    // ---------------- register decode ----------------
    logic       sel;
    logic [1:0] off;
    logic       addr_unused;
    logic       wr_data, wr_div, rd_data, rd_status;

    assign sel         = (io_addr[15:3] == BASE_ADDR[15:3]);
    assign off         = io_addr[2:1];
    assign addr_unused = io_addr[0];
    assign wr_data     = sel && io_wr && (off == REG_DATA);
    assign wr_div      = sel && io_wr && (off == REG_DIV);
    assign rd_data     = sel && io_rd && (off == REG_DATA);
    assign rd_status   = sel && io_rd && (off == REG_STATUS);

    logic [15:0] div_q;
    logic [15:0] div_eff;
    assign div_eff = div_clamp(div_q);

    // ---------------- TX FIFO ----------------
    logic [7:0] fifo_dout;
    logic       fifo_full, fifo_empty, fifo_drop, tx_pop;

    j1_io_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk       (sys_clk_i),
        .rst_n     (sys_rst_i),
        .push      (wr_data),
        .push_data (io_dout[7:0]),
        .pop       (tx_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // ---------------- TX FSM ----------------
    tx_state_e   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_idle;

    // STOP chains straight into START when another byte waits, so frames abut
    assign tx_pop  = !fifo_empty &&
                     ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == 16'd0));
    assign tx_idle = fifo_empty && (tx_state == TX_IDLE);

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            uart_tx_o <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state  <= TX_START;
                        tx_sh     <= fifo_dout;
                        tx_cnt    <= div_eff - 16'd1;
                        uart_tx_o <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state  <= TX_DATA;
                        tx_cnt    <= div_eff - 16'd1;
                        tx_bit    <= 3'd7;
                        uart_tx_o <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div_eff - 16'd1;
                        if (tx_bit == 3'd0) begin
                            tx_state  <= TX_STOP;
                            uart_tx_o <= 1'b1;
                        end else begin
                            tx_bit    <= tx_bit - 3'd1;
                            tx_sh     <= {1'b0, tx_sh[7:1]};
                            uart_tx_o <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            tx_state  <= TX_START;
                            tx_sh     <= fifo_dout;
                            tx_cnt    <= div_eff - 16'd1;
                            uart_tx_o <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX synchroniser and FSM ----------------
    logic        rx_meta, rx_sync, rx_prev;
    rx_state_e   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_done;

    assign rx_done = (rx_state == RX_STOP) && (rx_cnt == 16'd0);

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        // Land subsequent samples in the middle of each bit
                        rx_cnt   <= (div_eff >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= div_eff - 16'd1;
                            rx_bit   <= 3'd7;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_sh  <= {rx_sync, rx_sh[7:1]};
                        rx_cnt <= div_eff - 16'd1;
                        if (rx_bit == 3'd0) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit - 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- holding register, flags, divisor ----------------
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, rx_frame_err, tx_overflow;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            div_q        <= DIV_RESET;
        end else begin
            if (wr_div) div_q <= io_dout;

            // Clears first so that an event in the same cycle still gets recorded
            if (rd_status) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
                tx_overflow  <= 1'b0;
            end
            if (fifo_drop) tx_overflow <= 1'b1;

            if (rx_done) begin
                if (!rx_sync) rx_frame_err <= 1'b1;
                if (rx_valid && !rd_data) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_byte  <= rx_sh;
                    rx_valid <= 1'b1;
                end
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // ---------------- read mux ----------------
    logic [15:0] status;

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_IDLE]    = tx_idle;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_RX_FRAME]   = rx_frame_err;
        status[ST_TX_OVF]     = tx_overflow;
    end

    always_comb begin
        io_din = '0;
        if (sel) begin
            case (off)
                REG_DATA:   io_din = {8'h00, rx_byte};
                REG_STATUS: io_din = status;
                REG_DIV:    io_din = div_q;
                default:    io_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_j1_io_uart.sv
// tb/tb_j1_io_uart.sv - scoreboard testbench for j1_io_uart
module tb_j1_io_uart;

    localparam logic [15:0] A_DATA   = 16'h4000;
    localparam logic [15:0] A_STATUS = 16'h4002;
    localparam logic [15:0] A_DIV    = 16'h4004;
    localparam logic [15:0] A_R3     = 16'h4006;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i = 1'b0;
    logic        io_rd     = 1'b0;
    logic        io_wr     = 1'b0;
    logic [15:0] io_addr   = 16'h0;
    logic [15:0] io_dout   = 16'h0;
    logic [15:0] io_din;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;

    int n_checks = 0;
    int n_errors = 0;
    int bit_clks = 16;
    logic [15:0] tx_q[$];
    logic [7:0]  rx_q[$];
    logic [15:0] rd;

    always #5 sys_clk_i = ~sys_clk_i;

    j1_io_uart dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_din    (io_din),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk_i);
        #1;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        io_wr = 1'b1; io_addr = a; io_dout = d;
        wait_clks(1);
        io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        io_rd = 1'b1; io_addr = a;
        @(negedge sys_clk_i);
        d = io_din;
        wait_clks(1);
        io_rd = 1'b0;
    endtask

    task automatic io_rdwr(input logic [15:0] a, input logic [15:0] wd, output logic [15:0] d);
        io_rd = 1'b1; io_wr = 1'b1; io_addr = a; io_dout = wd;
        @(negedge sys_clk_i);
        d = io_din;
        wait_clks(1);
        io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        tx_q.push_back({8'h00, b});
        io_write(A_DATA, {8'h00, b});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            wait_clks(bit_clks);
        end
        uart_rx_i = stop;
        wait_clks(bit_clks);
        uart_rx_i = 1'b1;
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 4000 && tx_q.size() != 0; i++) wait_clks(1);
        check("tx_drain", 16'(tx_q.size()), 16'd0);
        wait_clks(bit_clks);
    endtask

    task automatic rx_read_check(input string tag);
        logic [15:0] exp;
        exp = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'hDEAD;
        io_read(A_DATA, rd);
        check(tag, rd, exp);
    endtask

    // TX line monitor: decodes each frame and compares it against the scoreboard
    initial begin : tx_monitor
        logic [7:0]  b;
        logic [15:0] exp;
        int          bc;
        forever begin
            @(negedge uart_tx_o);
            if (sys_rst_i) begin
                bc = bit_clks;
                repeat (bc / 2) @(negedge sys_clk_i);
                check("tx_start", {15'h0, uart_tx_o}, 16'h0000);
                for (int i = 0; i < 8; i++) begin
                    repeat (bc) @(negedge sys_clk_i);
                    b[i] = uart_tx_o;
                end
                repeat (bc) @(negedge sys_clk_i);
                check("tx_stop", {15'h0, uart_tx_o}, 16'h0001);
                exp = (tx_q.size() != 0) ? tx_q.pop_front() : 16'h0100;
                check("tx_byte", {8'h00, b}, exp);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset
        repeat (3) @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        check("rst_tx_line", {15'h0, uart_tx_o}, 16'h0001);
        @(posedge sys_clk_i);
        #1 sys_rst_i = 1'b1;
        wait_clks(2);
        io_read(A_STATUS, rd); check("rst_status", rd, 16'h0002);
        io_read(A_DIV, rd);    check("rst_div", rd, 16'd868);
        io_read(A_R3, rd);     check("reg3_zero", rd, 16'h0000);

        // Single byte TX at DIV=16
        bit_clks = 16;
        io_write(A_DIV, 16'd16);
        io_read(A_DIV, rd);    check("div_wr", rd, 16'd16);
        tx_byte(8'hA5);
        wait_clks(150);
        io_read(A_STATUS, rd); check("tx_busy_status", rd, 16'h0000);
        wait_clks(12);
        io_read(A_STATUS, rd); check("tx_idle_status", rd, 16'h0002);

        // FIFO fill and overflow
        for (int i = 0; i < 9; i++) tx_byte(8'h10 + 8'(i));
        io_read(A_STATUS, rd); check("tx_full", rd, 16'h0001);
        io_write(A_DATA, 16'h00EE);
        io_read(A_STATUS, rd); check("tx_overflow", rd, 16'h0021);
        io_read(A_STATUS, rd); check("tx_ovf_clear", rd, 16'h0001);
        wait_tx_drain();

        // Divisor below 2 behaves as 2
        io_write(A_DIV, 16'd0);
        io_read(A_DIV, rd);    check("div_zero_rd", rd, 16'd0);
        bit_clks = 2;
        tx_byte(8'hC3);
        wait_tx_drain();
        bit_clks = 16;
        io_write(A_DIV, 16'd16);

        // RX single byte
        rx_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        io_read(A_STATUS, rd); check("rx_valid_set", rd, 16'h0006);
        rx_read_check("rx_data_3c");
        io_read(A_STATUS, rd); check("rx_valid_clr", rd, 16'h0002);

        // Overrun: second byte dropped, first kept
        rx_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(20);
        io_read(A_STATUS, rd); check("rx_overrun", rd, 16'h000E);
        rx_read_check("rx_data_keep");
        io_read(A_STATUS, rd); check("rx_ovr_clear", rd, 16'h0002);

        // Framing error: byte still delivered
        rx_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        wait_clks(20);
        io_read(A_STATUS, rd); check("rx_frame_err", rd, 16'h0016);
        rx_read_check("rx_data_5a");
        io_read(A_STATUS, rd); check("rx_fe_clear", rd, 16'h0002);

        // Decode miss and simultaneous read+write of DATA
        rx_q.push_back(8'h77);
        send_frame(8'h77, 1'b1);
        wait_clks(20);
        io_read(16'h8000, rd); check("decode_miss", rd, 16'h0000);
        io_read(A_STATUS, rd); check("no_pop_miss", rd, 16'h0006);
        tx_q.push_back(16'h0042);
        io_rdwr(A_DATA, 16'h0042, rd);
        check("rdwr_rdata", rd, {8'h00, rx_q.pop_front()});
        io_read(A_STATUS, rd); check("rdwr_status", rd, 16'h0000);
        wait_tx_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
